// File: rtl/layer_test_sequencer_if.sv
// Tester-facing handshake and chain-side signals of the layer self-test sequencer.
// The slave modport is the sequencer; the master modport is the tester/chain side.
interface layer_test_sequencer_if #(
    parameter int SIG_LEN = 8
);
    logic               start;
    logic               abort;
    logic               sort_finish_0;
    logic               sort_finish_1;
    logic               chain_data;
    logic [SIG_LEN-1:0] expected_sig;
    logic               f_layer_0;
    logic               f_layer_1;
    logic               busy;
    logic               done;
    logic               pass;
    logic [1:0]         timeout_err;
    logic [SIG_LEN-1:0] signature;

    modport master (
        output start, abort, sort_finish_0, sort_finish_1, chain_data, expected_sig,
        input  f_layer_0, f_layer_1, busy, done, pass, timeout_err, signature
    );

    modport slave (
        input  start, abort, sort_finish_0, sort_finish_1, chain_data, expected_sig,
        output f_layer_0, f_layer_1, busy, done, pass, timeout_err, signature
    );
endinterface

// File: rtl/layer_test_sequencer.sv
// Runs layer 0 then layer 1 of the self-test chain with per-layer timeouts, shifts in a
// serial signature from the chain and reports done/pass. All outputs are registered.
module layer_test_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SIG_LEN        = 8
) (
    input  logic                    t_clk,
    input  logic                    rst,
    layer_test_sequencer_if.slave   bus
);
    localparam int CMAX = (TIMEOUT_CYCLES > SIG_LEN) ? TIMEOUT_CYCLES : SIG_LEN;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] C_SIGEND  = CW'(SIG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_L0,
        S_WAIT_L1,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_timeout_err;
    logic [SIG_LEN-1:0] r_signature;
    logic               r_pass;
    logic               r_f_layer_0;
    logic               r_f_layer_1;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [1:0]         w_timeout_err_nxt;
    logic [SIG_LEN-1:0] w_signature_nxt;
    logic               w_pass_nxt;

    always_ff @(posedge t_clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_timeout_err <= '0;
            r_signature   <= '0;
            r_pass        <= 1'b0;
            r_f_layer_0   <= 1'b0;
            r_f_layer_1   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_signature   <= w_signature_nxt;
            r_pass        <= w_pass_nxt;
            // Outputs decode the next state so they line up with the state they describe.
            r_f_layer_0   <= (w_state_nxt == S_WAIT_L0);
            r_f_layer_1   <= (w_state_nxt == S_WAIT_L1);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_done        <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_timeout_err_nxt = r_timeout_err;
        w_signature_nxt   = r_signature;
        w_pass_nxt        = r_pass;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt       = S_WAIT_L0;
                    w_cnt_nxt         = '0;
                    w_timeout_err_nxt = '0;
                    w_signature_nxt   = '0;
                    w_pass_nxt        = 1'b0;
                end
            end
            S_WAIT_L0: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (bus.sort_finish_0) begin
                    w_state_nxt = S_WAIT_L1;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_state_nxt          = S_DONE;
                    w_cnt_nxt            = '0;
                    w_timeout_err_nxt[0] = 1'b1;
                end
            end
            S_WAIT_L1: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (bus.sort_finish_1) begin
                    w_state_nxt = S_CAPTURE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_state_nxt          = S_DONE;
                    w_cnt_nxt            = '0;
                    w_timeout_err_nxt[1] = 1'b1;
                end
            end
            S_CAPTURE: begin
                // First captured bit ends up in the MSB.
                w_signature_nxt = {r_signature[SIG_LEN-2:0], bus.chain_data};
                w_cnt_nxt       = r_cnt + CW'(1);
                if (r_cnt == C_SIGEND) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            S_DONE: begin
                w_pass_nxt  = (r_timeout_err == 2'b00) && (r_signature == bus.expected_sig);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort outranks every transition; results are kept but the run cannot pass.
        if ((r_state != S_IDLE) && bus.abort) begin
            w_state_nxt       = S_IDLE;
            w_cnt_nxt         = '0;
            w_timeout_err_nxt = r_timeout_err;
            w_signature_nxt   = r_signature;
            w_pass_nxt        = 1'b0;
        end
    end

    assign bus.f_layer_0   = r_f_layer_0;
    assign bus.f_layer_1   = r_f_layer_1;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.timeout_err = r_timeout_err;
    assign bus.signature   = r_signature;
endmodule

// File: tb/tb_layer_test_sequencer.sv
// Directed bench for layer_test_sequencer: table of full runs plus hand-written
// abort/reset/start-hold sequences.
module tb_layer_test_sequencer;
    logic t_clk = 1'b0;
    logic rst   = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    layer_test_sequencer_if #(.SIG_LEN(8)) bus ();

    layer_test_sequencer #(.TIMEOUT_CYCLES(16), .SIG_LEN(8)) dut (
        .t_clk (t_clk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 t_clk = ~t_clk;

    typedef struct {
        int         a0;      // f_layer_0 cycle on which sort_finish_0 is raised (0 = never)
        int         a1;
        bit         early;   // stray start and sort_finish_1 during WAIT_L0
        logic [7:0] data;    // serial bits, MSB first
        logic [7:0] exp_in;
        int         lat;
        int         f0;
        int         f1;
        int         terr;
        int         sig;
        int         pass;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.sort_finish_0 = 1'b0;
        bus.sort_finish_1 = 1'b0;
        bus.chain_data    = 1'b0;
    endtask

    function automatic int all_outs();
        return int'({bus.f_layer_0, bus.f_layer_1, bus.busy, bus.done,
                     bus.pass, bus.timeout_err, bus.signature});
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int  n0 = 0;
        int  n1 = 0;
        int  c = 0;
        int  k = 0;
        int  lat = -1;
        int  ndone = 0;
        bit  both = 1'b0;
        bit  cap = 1'b0;
        bit  prev_fin = 1'b0;
        string p;
        p = $sformatf("v%0d_", idx);
        bus.expected_sig = v.exp_in;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 1;
        chk({p, "start_busy_f0"}, int'({bus.busy, bus.f_layer_0}), 3);
        while (c < 80) begin
            if (bus.f_layer_0) n0++;
            if (bus.f_layer_1) n1++;
            if (bus.f_layer_0 && bus.f_layer_1) both = 1'b1;
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = c;
            end
            bus.sort_finish_0 = bus.f_layer_0 && (v.a0 != 0) && (n0 == v.a0);
            bus.sort_finish_1 = bus.f_layer_1 ? (n1 == v.a1) : (bus.f_layer_0 && v.early);
            bus.start         = v.early && bus.f_layer_0 && (n0 == 2);
            if (prev_fin) cap = 1'b1;
            if (cap && k < 8) begin
                bus.chain_data = v.data[7-k];
                k++;
            end else begin
                bus.chain_data = 1'($urandom_range(0, 1));
            end
            prev_fin = bus.f_layer_1 && bus.sort_finish_1;
            if (lat >= 0 && c >= lat + 1) break;
            tick();
            c++;
        end
        chk({p, "done_latency"}, lat, v.lat);
        chk({p, "done_pulses"}, ndone, 1);
        chk({p, "f0_cycles"}, n0, v.f0);
        chk({p, "f1_cycles"}, n1, v.f1);
        chk({p, "f_overlap"}, int'(both), 0);
        chk({p, "timeout_err"}, int'(bus.timeout_err), v.terr);
        chk({p, "signature"}, int'(bus.signature), v.sig);
        chk({p, "pass"}, int'(bus.pass), v.pass);
        chk({p, "busy_after"}, int'(bus.busy), 0);
        idle_inputs();
    endtask

    // Drives start, immediate finishes on both layers, 8 capture cycles of zeros;
    // leaves the bench in the DONE cycle.
    task automatic quick_run_to_done();
        bus.expected_sig = 8'h00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.sort_finish_0 = 1'b1;
        tick();
        bus.sort_finish_0 = 1'b0;
        bus.sort_finish_1 = 1'b1;
        tick();
        bus.sort_finish_1 = 1'b0;
        bus.chain_data = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        int nd;
        //            a0  a1  early data   exp_in  lat f0  f1  terr sig   pass
        vecs[0] = '{3,  5,  1'b0, 8'hB2, 8'hB2, 17, 3,  5,  0, 'hB2, 1};
        vecs[1] = '{3,  5,  1'b0, 8'hB2, 8'hB3, 17, 3,  5,  0, 'hB2, 0};
        vecs[2] = '{0,  5,  1'b0, 8'hFF, 8'h00, 17, 16, 0,  1, 'h00, 0};
        vecs[3] = '{3,  16, 1'b0, 8'h5A, 8'h5A, 28, 3,  16, 0, 'h5A, 1};
        vecs[4] = '{3,  17, 1'b0, 8'h5A, 8'h00, 20, 3,  16, 2, 'h00, 0};
        vecs[5] = '{6,  2,  1'b1, 8'hC3, 8'hC3, 17, 6,  2,  0, 'hC3, 1};

        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.start         = 1'($urandom_range(0, 1));
            bus.abort         = 1'($urandom_range(0, 1));
            bus.sort_finish_0 = 1'($urandom_range(0, 1));
            bus.sort_finish_1 = 1'($urandom_range(0, 1));
            bus.chain_data    = 1'($urandom_range(0, 1));
            bus.expected_sig  = 8'($urandom);
            tick();
        end
        chk("reset_outputs", all_outs(), 0);
        chk("reset_busy", int'(bus.busy), 0);
        idle_inputs();
        rst = 1'b0;
        tick();
        chk("idle_after_reset", all_outs(), 0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Abort during CAPTURE after two captured ones
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.sort_finish_0 = 1'b1;
        tick();
        bus.sort_finish_0 = 1'b0;
        bus.sort_finish_1 = 1'b1;
        tick();
        bus.sort_finish_1 = 1'b0;
        bus.chain_data = 1'b1;
        tick();
        tick();
        bus.abort = 1'b1;
        bus.chain_data = 1'b0;
        tick();
        bus.abort = 1'b0;
        chk("abort_cap_busy", int'(bus.busy), 0);
        chk("abort_cap_f", int'({bus.f_layer_0, bus.f_layer_1}), 0);
        chk("abort_cap_done", int'(bus.done), 0);
        chk("abort_cap_pass", int'(bus.pass), 0);
        chk("abort_cap_sig_held", int'(bus.signature), 'h03);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done) nd++;
        end
        chk("abort_cap_no_done", nd, 0);

        // Abort in the DONE cycle of an otherwise passing run forces pass low
        quick_run_to_done();
        chk("quick_done_pulse", int'(bus.done), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_done_pass", int'(bus.pass), 0);
        chk("abort_done_busy", int'(bus.busy), 0);

        // Same run without abort passes
        quick_run_to_done();
        tick();
        chk("quick_pass", int'(bus.pass), 1);

        // start held high through DONE -> IDLE restarts from IDLE
        quick_run_to_done();
        bus.start = 1'b1;
        tick();
        chk("hold_start_idle_busy", int'(bus.busy), 0);
        chk("hold_start_idle_done", int'(bus.done), 0);
        tick();
        bus.start = 1'b0;
        chk("hold_start_restart", int'({bus.busy, bus.f_layer_0}), 3);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("hold_start_abort_idle", int'(bus.busy), 0);

        // rst during WAIT_L1
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.sort_finish_0 = 1'b1;
        tick();
        bus.sort_finish_0 = 1'b0;
        chk("wait_l1_f1", int'({bus.f_layer_0, bus.f_layer_1}), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_outputs", all_outs(), 0);
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done || bus.busy) nd++;
        end
        chk("rst_mid_stays_idle", nd, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
